ser_frame_ctrl: RTL and testbench

- Frame controller for the serial receive path; sits between the serial line and the `seq_detector` preamble detector.
- After the detector reports the preamble, the block does four things in order:
  - shifts in a port-address header and a length header;
  - routes the payload bits to one of 2**PORT_W output channels;
  - clears the detector;
  - re-arms the hunt for the next frame.
- Sequences and re-arms the detector; owns all framing, counting and routing state.

---
 rtl/ser_frame_ctrl_if.sv | 28 ++
 rtl/ser_frame_ctrl.sv | 138 +++++++++++++
 tb/tb_ser_frame_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ser_frame_ctrl_if.sv
// Signal bundle between the frame controller and the serial receive path.
// master: the frame controller. slave: the line/detector side.
interface ser_frame_ctrl_if #(
    parameter int PORT_W = 2
);
    localparam int NP = 2 ** PORT_W;

    logic              ser_in;
    logic              detected;
    logic              det_clr;
    logic              data_out;
    logic [NP-1:0]     out_en;
    logic [PORT_W-1:0] port_sel;
    logic              busy;
    logic              done;
    logic              parity_err;
    logic [7:0]        frame_cnt;

    modport master (
        input  ser_in, detected,
        output det_clr, data_out, out_en, port_sel, busy, done, parity_err, frame_cnt
    );

    modport slave (
        output ser_in, detected,
        input  det_clr, data_out, out_en, port_sel, busy, done, parity_err, frame_cnt
    );
endinterface

// File: rtl/ser_frame_ctrl.sv
// ser_frame_ctrl: frame controller for the serial receive path.
// After the preamble detector fires, it shifts in an address and a length
// header (MSB first), routes L payload bits to one of 2**PORT_W channels,
// pulses det_clr for one cycle, and re-arms the hunt for the next frame.
// Optional trailing even-parity bit: define SER_PARITY_EN.
// LEN_W must be at least 2; PORT_W is 2..4.
module ser_frame_ctrl #(
    parameter int PORT_W = 2,
    parameter int LEN_W  = 4
) (
    input logic          clk,
    input logic          rst,
    ser_frame_ctrl_if.master bus
);
    localparam int NP = 2 ** PORT_W;
    localparam int CW = (PORT_W > LEN_W) ? PORT_W : LEN_W;

    localparam logic [2:0] HUNT   = 3'd0;
    localparam logic [2:0] ADDR   = 3'd1;
    localparam logic [2:0] LEN    = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
`ifdef SER_PARITY_EN
    localparam logic [2:0] PARITY = 3'd5;
    localparam logic [2:0] POST   = PARITY;
`else
    localparam logic [2:0] POST   = DONE;
`endif

    logic [2:0]        state;
    logic [2:0]        stateNext;
    logic [CW-1:0]     bitCnt;
    logic [LEN_W-2:0]  lenReg;
    logic [LEN_W-1:0]  lenNext;
    logic [LEN_W-1:0]  dataCnt;
    logic [PORT_W-1:0] portSel;
    logic [PORT_W-1:0] portShift;
    logic [7:0]        frameCnt;
    logic              detClr;
    logic [NP-1:0]     outEn;

    // The length register keeps only the low bits; the final bit completes L
    assign lenNext   = {lenReg, bus.ser_in};
    assign portShift = {portSel[PORT_W-2:0], bus.ser_in};

    // Next-state decode; detected only matters while hunting
    always_comb begin
        stateNext = state;
        case (state)
            HUNT:   if (bus.detected) stateNext = ADDR;
            ADDR:   if (bitCnt == '0) stateNext = LEN;
            LEN:    if (bitCnt == '0) stateNext = (lenNext == '0) ? POST : DATA;
            DATA:   if (dataCnt == LEN_W'(1)) stateNext = POST;
`ifdef SER_PARITY_EN
            PARITY: stateNext = DONE;
`endif
            DONE:   stateNext = HUNT;
            default: stateNext = HUNT;
        endcase
    end

    // State, header shifting, payload counting, frame counter and det_clr flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HUNT;
            detClr   <= 1'b1;
            bitCnt   <= '0;
            lenReg   <= '0;
            dataCnt  <= '0;
            portSel  <= '0;
            frameCnt <= '0;
        end else begin
            state  <= stateNext;
            detClr <= (stateNext == DONE);
            case (state)
                HUNT: begin
                    if (bus.detected) begin
                        portSel <= portShift;
                        bitCnt  <= CW'(PORT_W - 2);
                    end
                end
                ADDR: begin
                    portSel <= portShift;
                    if (bitCnt == '0) bitCnt <= CW'(LEN_W - 1);
                    else              bitCnt <= bitCnt - 1'b1;
                end
                LEN: begin
                    lenReg <= lenNext[LEN_W-2:0];
                    if (bitCnt == '0) dataCnt <= lenNext;
                    else              bitCnt  <= bitCnt - 1'b1;
                end
                DATA: begin
                    dataCnt <= dataCnt - 1'b1;
                end
                DONE: begin
                    if (frameCnt != 8'hFF) frameCnt <= frameCnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // One-hot strobe for the captured channel, only while payload is flowing
    always_comb begin
        outEn = '0;
        if (state == DATA) outEn[portSel] = 1'b1;
    end

`ifdef SER_PARITY_EN
    logic parAcc;
    logic parErr;

    // Running XOR over the payload, cleared as the length header completes;
    // the error flag is set only on the edge from PARITY into DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parAcc <= 1'b0;
            parErr <= 1'b0;
        end else begin
            if (state == LEN && bitCnt == '0) parAcc <= 1'b0;
            else if (state == DATA)           parAcc <= parAcc ^ bus.ser_in;
            parErr <= (state == PARITY) && (bus.ser_in != parAcc);
        end
    end

    assign bus.parity_err = parErr;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.det_clr   = detClr;
    assign bus.data_out  = bus.ser_in;
    assign bus.out_en    = outEn;
    assign bus.port_sel  = portSel;
    assign bus.busy      = (state != HUNT);
    assign bus.done      = (state == DONE);
    assign bus.frame_cnt = frameCnt;
endmodule

// File: tb/tb_ser_frame_ctrl.sv
// Testbench for ser_frame_ctrl: behavioural preamble detector plus a
// scoreboard of expected payload strobes and end-of-frame pulses.
module tb_ser_frame_ctrl;
    localparam int PORT_W = 2;
    localparam int LEN_W  = 4;
    localparam int NP     = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    ser_frame_ctrl_if #(.PORT_W(PORT_W)) bus();

    ser_frame_ctrl #(.PORT_W(PORT_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sticky detector model for preamble 0111110, cleared by det_clr
    logic [5:0] hist;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist         <= '0;
            bus.detected <= 1'b0;
        end else if (bus.det_clr) begin
            hist         <= '0;
            bus.detected <= 1'b0;
        end else begin
            hist <= {hist[4:0], bus.ser_in};
            if ({hist, bus.ser_in} == 7'b0111110) bus.detected <= 1'b1;
        end
    end

    typedef struct {
        int            cyc;
        logic [NP-1:0] en;
        logic          bitv;
    } dataExp_t;

    typedef struct {
        int                cyc;
        logic [PORT_W-1:0] port;
        logic [7:0]        cnt;
        logic              perr;
    } doneExp_t;

    dataExp_t sbData[$];
    doneExp_t sbDone[$];
    dataExp_t monD;
    doneExp_t monE;

    int checks   = 0;
    int fails    = 0;
    int modelCnt = 0;

    function automatic logic [NP-1:0] oneHot(input logic [PORT_W-1:0] a);
        logic [NP-1:0] v;
        v = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT strobes a payload bit or ends a frame
    always @(negedge clk) begin
        if (rst) begin
            if (bus.out_en !== '0) begin
                checks++;
                if (sbData.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_out_en cyc=%0d got out_en=%b required none", cyc, bus.out_en);
                end else begin
                    monD = sbData.pop_front();
                    if (monD.cyc !== cyc || bus.out_en !== monD.en || bus.data_out !== monD.bitv) begin
                        fails++;
                        $display("[TB] FAIL payload_bit got cyc=%0d out_en=%b data=%b required cyc=%0d out_en=%b data=%b",
                                 cyc, bus.out_en, bus.data_out, monD.cyc, monD.en, monD.bitv);
                    end
                end
            end
            checks++;
            if (bus.done === 1'b1) begin
                if (sbDone.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_done cyc=%0d got done=1 required 0", cyc);
                end else begin
                    monE = sbDone.pop_front();
                    if (monE.cyc !== cyc || bus.port_sel !== monE.port || bus.frame_cnt !== monE.cnt ||
                        bus.parity_err !== monE.perr || bus.det_clr !== 1'b1 || bus.busy !== 1'b1) begin
                        fails++;
                        $display("[TB] FAIL done_pulse got cyc=%0d port=%0d cnt=%0d perr=%b det_clr=%b busy=%b required cyc=%0d port=%0d cnt=%0d perr=%b det_clr=1 busy=1",
                                 cyc, bus.port_sel, bus.frame_cnt, bus.parity_err, bus.det_clr, bus.busy,
                                 monE.cyc, monE.port, monE.cnt, monE.perr);
                    end
                end
            end else if (bus.parity_err !== 1'b0) begin
                fails++;
                $display("[TB] FAIL parity_outside_done cyc=%0d got parity_err=%b required 0", cyc, bus.parity_err);
            end
        end
    end

    // Drive one bit for one clock; callers stay aligned 1 time unit after a rising edge
    task automatic driveBit(input logic b);
        bus.ser_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic sendHeader(input logic [PORT_W-1:0] addr, input logic [LEN_W-1:0] len);
        logic [6:0] pre;
        pre = 7'b0111110;
        for (int i = 6; i >= 0; i--) driveBit(pre[i]);
        for (int i = PORT_W - 1; i >= 0; i--) driveBit(addr[i]);
        for (int i = LEN_W - 1; i >= 0; i--) driveBit(len[i]);
    endtask

    // Full frame; payload[0] is sent first
    task automatic sendFrame(input logic [PORT_W-1:0] addr, input logic [LEN_W-1:0] len,
                             input logic [15:0] payload, input logic parBit);
        logic [15:0] mask;
        logic        expPerr;
        sendHeader(addr, len);
        for (int i = 0; i < int'(len); i++) begin
            sbData.push_back('{cyc, oneHot(addr), payload[i]});
            driveBit(payload[i]);
        end
        mask = (16'd1 << len) - 16'd1;
`ifdef SER_PARITY_EN
        driveBit(parBit);
        expPerr = parBit ^ (^(payload & mask));
`else
        expPerr = 1'b0 & parBit & (^mask);
`endif
        sbDone.push_back('{cyc, addr, 8'(modelCnt), expPerr});
        if (modelCnt < 255) modelCnt++;
        driveBit(1'b0);
    endtask

    task automatic test_reset();
        bus.ser_in = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.det_clr !== 1'b1 || bus.busy !== 1'b0 || bus.out_en !== '0 || bus.frame_cnt !== 8'd0 ||
            bus.done !== 1'b0 || bus.port_sel !== '0 || bus.parity_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_values got det_clr=%b busy=%b out_en=%b cnt=%0d done=%b port=%0d perr=%b required 1 0 0000 0 0 0 0",
                     bus.det_clr, bus.busy, bus.out_en, bus.frame_cnt, bus.done, bus.port_sel, bus.parity_err);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.det_clr !== 1'b0 || bus.busy !== 1'b0 || bus.out_en !== '0 || bus.frame_cnt !== 8'd0) begin
            fails++;
            $display("[TB] FAIL after_release got det_clr=%b busy=%b out_en=%b cnt=%0d required 0 0 0000 0",
                     bus.det_clr, bus.busy, bus.out_en, bus.frame_cnt);
        end
        modelCnt = 0;
    endtask

    task automatic test_basic_frame();
        sendFrame(2'd2, 4'd3, 16'b101, 1'b0);
        checks++;
        if (bus.port_sel !== 2'd2 || bus.frame_cnt !== 8'(modelCnt) || bus.busy !== 1'b0 ||
            sbData.size() != 0 || sbDone.size() != 0) begin
            fails++;
            $display("[TB] FAIL basic_frame got port=%0d cnt=%0d busy=%b pending=%0d/%0d required port=2 cnt=%0d busy=0 pending=0/0",
                     bus.port_sel, bus.frame_cnt, bus.busy, sbData.size(), sbDone.size(), modelCnt);
        end
        sbData.delete();
        sbDone.delete();
    endtask

    task automatic test_zero_length();
        sendFrame(2'd2, 4'd0, 16'h0000, 1'b0);
        checks++;
        if (bus.frame_cnt !== 8'(modelCnt) || sbDone.size() != 0) begin
            fails++;
            $display("[TB] FAIL zero_length got cnt=%0d pending_done=%0d required cnt=%0d pending_done=0",
                     bus.frame_cnt, sbDone.size(), modelCnt);
        end
        sbDone.delete();
    endtask

    task automatic test_reset_mid_frame();
        sendHeader(2'd1, 4'd5);
        sbData.push_back('{cyc, oneHot(2'd1), 1'b1});
        driveBit(1'b1);
        bus.ser_in = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_en !== '0 || bus.busy !== 1'b0 || bus.frame_cnt !== 8'd0 || bus.done !== 1'b0 ||
            bus.det_clr !== 1'b1 || bus.port_sel !== '0) begin
            fails++;
            $display("[TB] FAIL mid_frame_reset got out_en=%b busy=%b cnt=%0d done=%b det_clr=%b port=%0d required 0000 0 0 0 1 0",
                     bus.out_en, bus.busy, bus.frame_cnt, bus.done, bus.det_clr, bus.port_sel);
        end
        modelCnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sendFrame(2'd1, 4'd2, 16'b10, 1'b1);
        checks++;
        if (bus.frame_cnt !== 8'd1 || sbData.size() != 0 || sbDone.size() != 0) begin
            fails++;
            $display("[TB] FAIL frame_after_reset got cnt=%0d pending=%0d/%0d required cnt=1 pending=0/0",
                     bus.frame_cnt, sbData.size(), sbDone.size());
        end
        sbData.delete();
        sbDone.delete();
    endtask

    task automatic test_back_to_back();
        int startCnt;
        startCnt = modelCnt;
        sendFrame(2'd2, 4'd3, 16'b101, 1'b0);
        sendFrame(2'd3, 4'd7, 16'b0111110, 1'b1);
        repeat (12) driveBit(1'b0);
        checks++;
        if (bus.frame_cnt !== 8'(startCnt + 2) || bus.busy !== 1'b0 || sbData.size() != 0 || sbDone.size() != 0) begin
            fails++;
            $display("[TB] FAIL back_to_back got cnt=%0d busy=%b pending=%0d/%0d required cnt=%0d busy=0 pending=0/0",
                     bus.frame_cnt, bus.busy, sbData.size(), sbDone.size(), startCnt + 2);
        end
        sbData.delete();
        sbDone.delete();
    endtask

    task automatic test_parity();
        sendFrame(2'd1, 4'd3, 16'b011, 1'b1);
        sendFrame(2'd1, 4'd3, 16'b011, 1'b0);
        sendFrame(2'd0, 4'd0, 16'h0000, 1'b1);
        checks++;
        if (bus.frame_cnt !== 8'(modelCnt) || sbData.size() != 0 || sbDone.size() != 0) begin
            fails++;
            $display("[TB] FAIL parity_frames got cnt=%0d pending=%0d/%0d required cnt=%0d pending=0/0",
                     bus.frame_cnt, sbData.size(), sbDone.size(), modelCnt);
        end
        sbData.delete();
        sbDone.delete();
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 256; n++) sendFrame(2'(n), 4'd0, 16'h0000, 1'b0);
        checks++;
        if (bus.frame_cnt !== 8'd255 || sbDone.size() != 0) begin
            fails++;
            $display("[TB] FAIL saturation got cnt=%0d pending_done=%0d required cnt=255 pending_done=0",
                     bus.frame_cnt, sbDone.size());
        end
        sbDone.delete();
    endtask

    initial begin
        bus.ser_in = 1'b0;
        test_reset();
        test_basic_frame();
        test_zero_length();
        test_reset_mid_frame();
        test_back_to_back();
        test_parity();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
